// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one synchronous single-port memory between instruction fetch and load/store.
// Load/store has priority; a bounded starvation counter lets a waiting fetch through.
module mem_arbiter #(
  parameter int unsigned LS_MAX = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_ready_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        ls_req_i,
  input  logic [31:0] ls_addr_i,
  input  logic [1:0]  ls_store_size_i,
  input  logic [31:0] ls_wdata_i,
  output logic        ls_ready_o,
  output logic        ls_rvalid_o,
  output logic [31:0] ls_rdata_o,
  output logic        ls_misaligned_o,
  output logic        mem_en_o,
  output logic [3:0]  mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned CW = $clog2(LS_MAX + 1);
  localparam logic [CW-1:0] LS_MAX_C = CW'(LS_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_WAIT = 2'd1,
    LS_WAIT = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;

  logic        idle_s, ls_grant_s, if_grant_s, mis_s, ls_access_s, is_load_s;
  logic [3:0]  we_s;
  logic [31:0] wdata_s;

  // Grant decision, store lane steering and next-state logic
  always_comb begin
    idle_s     = rst_ni && (state_q == IDLE);
    ls_grant_s = idle_s && ls_req_i && !(if_req_i && (starve_q == LS_MAX_C));
    if_grant_s = idle_s && if_req_i && !ls_grant_s;
    is_load_s  = (ls_store_size_i == 2'b11);

    case (ls_store_size_i)
      2'b00:   begin
        mis_s   = 1'b0;
        we_s    = 4'b0001 << ls_addr_i[1:0];
        wdata_s = {4{ls_wdata_i[7:0]}};
      end
      2'b01:   begin
        mis_s   = ls_addr_i[0];
        we_s    = 4'b0011 << {ls_addr_i[1], 1'b0};
        wdata_s = {2{ls_wdata_i[15:0]}};
      end
      2'b10:   begin
        mis_s   = (ls_addr_i[1:0] != 2'b00);
        we_s    = 4'b1111;
        wdata_s = ls_wdata_i;
      end
      default: begin
        mis_s   = (ls_addr_i[1:0] != 2'b00);
        we_s    = 4'b0000;
        wdata_s = ls_wdata_i;
      end
    endcase

    ls_access_s     = ls_grant_s && !mis_s;
    if_ready_o      = if_grant_s;
    ls_ready_o      = ls_grant_s;
    ls_misaligned_o = ls_grant_s && mis_s;
    mem_en_o        = if_grant_s || ls_access_s;
    mem_we_o        = ls_access_s ? we_s : 4'b0000;
    mem_wdata_o     = wdata_s;
    mem_addr_o      = (if_grant_s ? if_addr_i : ls_addr_i) & 32'hFFFF_FFFC;

    case (state_q)
      IDLE: begin
        if (if_grant_s) begin
          state_d = IF_WAIT;
        end else if (ls_access_s && is_load_s) begin
          state_d = LS_WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      IF_WAIT: state_d = IDLE;
      LS_WAIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Misaligned accepts still count toward starvation
    if (!if_req_i || if_grant_s) begin
      starve_d = {CW{1'b0}};
    end else if (ls_grant_s && (starve_q != LS_MAX_C)) begin
      starve_d = starve_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      starve_d = starve_q;
    end
  end

  // Read-return strobes come straight from the wait states; data is zeroed outside them
  always_comb begin
    if_rvalid_o = (state_q == IF_WAIT);
    ls_rvalid_o = (state_q == LS_WAIT);
    if_rdata_o  = if_rvalid_o ? mem_rdata_i : 32'h0000_0000;
    ls_rdata_o  = ls_rvalid_o ? mem_rdata_i : 32'h0000_0000;
  end

  // FSM state and starvation counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      starve_q <= {CW{1'b0}};
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a small synchronous memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready, if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req;
  logic [31:0] ls_addr;
  logic [1:0]  ls_size;
  logic [31:0] ls_wdata;
  logic        ls_ready, ls_rvalid, ls_mis;
  logic [31:0] ls_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  int checks = 0;
  int failures = 0;

  mem_arbiter #(.LS_MAX(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_ready_o(if_ready),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .ls_req_i(ls_req), .ls_addr_i(ls_addr), .ls_store_size_i(ls_size),
    .ls_wdata_i(ls_wdata), .ls_ready_o(ls_ready), .ls_rvalid_o(ls_rvalid),
    .ls_rdata_o(ls_rdata), .ls_misaligned_o(ls_mis),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:255];
  logic        mem_init = 1'b0;

  // Synchronous byte-lane memory, preloaded on the first clock edge
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[8'h40] <= 32'hDEAD_BEEF;
      mem[8'h41] <= 32'h1234_5678;
      mem[8'h10] <= 32'h0BAD_F00D;
      mem_init   <= 1'b1;
    end else if (mem_en) begin
      if (mem_we == 4'b0000) begin
        mem_rdata <= mem[mem_addr[9:2]];
      end else begin
        if (mem_we[0]) mem[mem_addr[9:2]][7:0]   <= mem_wdata[7:0];
        if (mem_we[1]) mem[mem_addr[9:2]][15:8]  <= mem_wdata[15:8];
        if (mem_we[2]) mem[mem_addr[9:2]][23:16] <= mem_wdata[23:16];
        if (mem_we[3]) mem[mem_addr[9:2]][31:24] <= mem_wdata[31:24];
      end
    end
  end

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = 32'h0;
    ls_req = 1'b0; ls_addr = 32'h0; ls_size = 2'b00; ls_wdata = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100;
    ls_req = 1'b1; ls_addr = 32'h203; ls_size = 2'b00; ls_wdata = 32'hAB;
    #1;
    checks++; if (if_ready !== 1'b0) begin failures++; $display("FAIL rst_if_ready got=%0b exp=0", if_ready); end
    checks++; if (ls_ready !== 1'b0) begin failures++; $display("FAIL rst_ls_ready got=%0b exp=0", ls_ready); end
    checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL rst_mem_en got=%0b exp=0", mem_en); end
    checks++; if (mem_we !== 4'b0000) begin failures++; $display("FAIL rst_mem_we got=%b exp=0000", mem_we); end
    checks++; if (ls_mis !== 1'b0) begin failures++; $display("FAIL rst_mis got=%0b exp=0", ls_mis); end
    checks++; if ({if_rvalid, ls_rvalid} !== 2'b00) begin failures++; $display("FAIL rst_rvalid got=%b exp=00", {if_rvalid, ls_rvalid}); end
    checks++; if ({if_rdata, ls_rdata} !== 64'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", {if_rdata, ls_rdata}); end
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_fetch();
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100;
    #1;
    checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL fetch_ready got=%0b exp=1", if_ready); end
    checks++; if (mem_en !== 1'b1 || mem_we !== 4'b0000) begin failures++; $display("FAIL fetch_mem got en=%0b we=%b exp en=1 we=0000", mem_en, mem_we); end
    checks++; if (mem_addr !== 32'h100) begin failures++; $display("FAIL fetch_addr got=%h exp=00000100", mem_addr); end
    @(negedge clk);
    if_addr = 32'h104;
    #1;
    checks++; if (if_ready !== 1'b0 || mem_en !== 1'b0) begin failures++; $display("FAIL fetch_wait got ready=%0b en=%0b exp 0 0", if_ready, mem_en); end
    checks++; if (if_rvalid !== 1'b1) begin failures++; $display("FAIL fetch_rvalid got=%0b exp=1", if_rvalid); end
    checks++; if (if_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL fetch_rdata got=%h exp=deadbeef", if_rdata); end
    @(negedge clk);
    #1;
    checks++; if (if_ready !== 1'b1 || if_rvalid !== 1'b0) begin failures++; $display("FAIL fetch_regrant got ready=%0b rvalid=%0b exp 1 0", if_ready, if_rvalid); end
    checks++; if (mem_addr !== 32'h104) begin failures++; $display("FAIL fetch_addr2 got=%h exp=00000104", mem_addr); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h1234_5678) begin failures++; $display("FAIL fetch_rdata2 got v=%0b d=%h exp 1 12345678", if_rvalid, if_rdata); end
  endtask

  task automatic test_stores();
    @(negedge clk);
    ls_req = 1'b1; ls_size = 2'b00; ls_addr = 32'h203; ls_wdata = 32'h0000_00AB;
    #1;
    checks++; if (ls_ready !== 1'b1 || ls_mis !== 1'b0 || mem_en !== 1'b1) begin failures++; $display("FAIL byte_accept got r=%0b m=%0b en=%0b exp 1 0 1", ls_ready, ls_mis, mem_en); end
    checks++; if (mem_we !== 4'b1000) begin failures++; $display("FAIL byte_we got=%b exp=1000", mem_we); end
    checks++; if (mem_wdata !== 32'hABAB_ABAB) begin failures++; $display("FAIL byte_wdata got=%h exp=abababab", mem_wdata); end
    checks++; if (mem_addr !== 32'h200) begin failures++; $display("FAIL byte_addr got=%h exp=00000200", mem_addr); end
    @(negedge clk);
    ls_size = 2'b01; ls_addr = 32'h202; ls_wdata = 32'h0000_1234;
    #1;
    checks++; if (ls_ready !== 1'b1 || ls_rvalid !== 1'b0) begin failures++; $display("FAIL half_b2b got r=%0b rv=%0b exp 1 0", ls_ready, ls_rvalid); end
    checks++; if (mem_we !== 4'b1100 || mem_wdata !== 32'h1234_1234) begin failures++; $display("FAIL half_lanes got we=%b d=%h exp 1100 12341234", mem_we, mem_wdata); end
    @(negedge clk);
    ls_size = 2'b10; ls_addr = 32'h204; ls_wdata = 32'hCAFE_F00D;
    #1;
    checks++; if (ls_ready !== 1'b1 || mem_we !== 4'b1111 || mem_wdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL word_store got r=%0b we=%b d=%h exp 1 1111 cafef00d", ls_ready, mem_we, mem_wdata); end
    @(negedge clk);
    ls_size = 2'b11; ls_addr = 32'h200;
    #1;
    checks++; if (ls_ready !== 1'b1 || mem_en !== 1'b1 || mem_we !== 4'b0000) begin failures++; $display("FAIL load_grant got r=%0b en=%0b we=%b exp 1 1 0000", ls_ready, mem_en, mem_we); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (ls_rvalid !== 1'b1 || ls_rdata !== 32'h1234_0000) begin failures++; $display("FAIL load_rdata got v=%0b d=%h exp 1 12340000", ls_rvalid, ls_rdata); end
  endtask

  task automatic test_misaligned();
    @(negedge clk);
    ls_req = 1'b1; ls_size = 2'b11; ls_addr = 32'h102;
    #1;
    checks++; if (ls_ready !== 1'b1 || ls_mis !== 1'b1) begin failures++; $display("FAIL mis_load_flag got r=%0b m=%0b exp 1 1", ls_ready, ls_mis); end
    checks++; if (mem_en !== 1'b0 || mem_we !== 4'b0000) begin failures++; $display("FAIL mis_load_mem got en=%0b we=%b exp 0 0000", mem_en, mem_we); end
    @(negedge clk);
    ls_size = 2'b01; ls_addr = 32'h201; ls_wdata = 32'h0000_FFFF;
    #1;
    checks++; if (ls_rvalid !== 1'b0) begin failures++; $display("FAIL mis_no_rvalid got=%0b exp=0", ls_rvalid); end
    checks++; if (ls_ready !== 1'b1 || ls_mis !== 1'b1 || mem_en !== 1'b0 || mem_we !== 4'b0000) begin failures++; $display("FAIL mis_half got r=%0b m=%0b en=%0b we=%b exp 1 1 0 0000", ls_ready, ls_mis, mem_en, mem_we); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (ls_rvalid !== 1'b0 || ls_mis !== 1'b0) begin failures++; $display("FAIL mis_after got rv=%0b m=%0b exp 0 0", ls_rvalid, ls_mis); end
  endtask

  task automatic test_starvation();
    logic exp_if [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic exp_ls [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h100;
      ls_req = 1'b1; ls_size = 2'b10; ls_addr = 32'h300; ls_wdata = 32'(c);
      #1;
      checks++; if (if_ready !== exp_if[c] || ls_ready !== exp_ls[c]) begin failures++; $display("FAIL starve_c%0d got if=%0b ls=%0b exp if=%0b ls=%0b", c, if_ready, ls_ready, exp_if[c], exp_ls[c]); end
      if (c == 5) begin
        checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL starve_rdata got v=%0b d=%h exp 1 deadbeef", if_rvalid, if_rdata); end
      end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (if_rvalid !== 1'b1) begin failures++; $display("FAIL starve_rvalid2 got=%0b exp=1", if_rvalid); end
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h104;
    ls_req = 1'b1; ls_size = 2'b11; ls_addr = 32'h40;
    #1;
    checks++; if (ls_ready !== 1'b1 || if_ready !== 1'b0 || mem_addr !== 32'h40) begin failures++; $display("FAIL simul_ls_first got ls=%0b if=%0b a=%h exp 1 0 00000040", ls_ready, if_ready, mem_addr); end
    @(negedge clk);
    ls_req = 1'b0;
    #1;
    checks++; if (ls_rvalid !== 1'b1 || ls_rdata !== 32'h0BAD_F00D || if_ready !== 1'b0) begin failures++; $display("FAIL simul_ls_data got v=%0b d=%h if=%0b exp 1 0badf00d 0", ls_rvalid, ls_rdata, if_ready); end
    @(negedge clk);
    #1;
    checks++; if (if_ready !== 1'b1 || mem_addr !== 32'h104) begin failures++; $display("FAIL simul_if_grant got r=%0b a=%h exp 1 00000104", if_ready, mem_addr); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h1234_5678) begin failures++; $display("FAIL simul_if_data got v=%0b d=%h exp 1 12345678", if_rvalid, if_rdata); end
  endtask

  task automatic test_reset_mid_load();
    @(negedge clk);
    ls_req = 1'b1; ls_size = 2'b11; ls_addr = 32'h40;
    #1;
    checks++; if (ls_ready !== 1'b1) begin failures++; $display("FAIL rml_grant got=%0b exp=1", ls_ready); end
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    #1;
    checks++; if (ls_rvalid !== 1'b0 || ls_rdata !== 32'h0) begin failures++; $display("FAIL rml_drop got v=%0b d=%h exp 0 0", ls_rvalid, ls_rdata); end
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100;
    #1;
    checks++; if (ls_rvalid !== 1'b0 || if_ready !== 1'b0) begin failures++; $display("FAIL rml_hold got rv=%0b if=%0b exp 0 0", ls_rvalid, if_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (if_ready !== 1'b1 || ls_rvalid !== 1'b0) begin failures++; $display("FAIL rml_first_grant got if=%0b rv=%0b exp 1 0", if_ready, ls_rvalid); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEAD_BEEF || ls_rvalid !== 1'b0) begin failures++; $display("FAIL rml_fetch got v=%0b d=%h lv=%0b exp 1 deadbeef 0", if_rvalid, if_rdata, ls_rvalid); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_stores();
    test_misaligned();
    test_starvation();
    test_simultaneous();
    test_reset_mid_load();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LS_MAX, default 4: max consecutive load/store grants while a fetch request waits.
REQ-002 CLK  in  1  single clock; all state updates on rising edge.
REQ-003 RST_N  in  1  reset, asynchronous, active-low.
REQ-004 if_req  in  1  fetch request; if_addr is valid.
REQ-005 if_addr  in  32  fetch byte address, word-aligned.
REQ-006 if_ready  out  1  fetch request accepted this cycle.
REQ-007 if_rvalid  out  1  fetch read data valid, one-cycle pulse.
REQ-008 if_rdata  out  32  fetch read data.
REQ-009 ls_req  in  1  load/store request.
REQ-010 ls_addr  in  32  load/store byte address.
REQ-011 ls_store_size  in  2  00 byte store, 01 half store, 10 word store, 11 load.
REQ-012 ls_wdata  in  32  store data, right-justified.
REQ-013 ls_ready  out  1  load/store request accepted this cycle.
REQ-014 ls_rvalid  out  1  load data valid, one-cycle pulse; loads only.
REQ-015 ls_rdata  out  32  load data; full aligned word, extension done downstream.
REQ-016 ls_misaligned  out  1  one-cycle pulse: accepted access was misaligned.
REQ-017 mem_en  out  1  memory access this cycle.
REQ-018 mem_we  out  4  byte write enables; 0000 on reads.
REQ-019 mem_addr  out  32  word address = request address with bits [1:0] forced to 00.
REQ-020 mem_wdata  out  32  store data lane-replicated.
REQ-021 mem_rdata  in  32  synchronous memory read data, valid exactly 1 cycle after mem_en with mem_we=0000.

Function
REQ-022 FSM states: IDLE, IF_WAIT, LS_WAIT.
REQ-023 Grants are made only in IDLE. ready, mem_en, mem_addr, mem_we, and mem_wdata are combinational in the grant cycle.
REQ-024 Requesters hold req/addr/data stable until ready; the arbiter never accepts without ready.
REQ-025 Both requests present in IDLE: grant ls, unless starve_cnt == LS_MAX, then grant if.
REQ-026 starve_cnt: +1 on each ls grant while if_req=1, saturating at LS_MAX; cleared on any if grant or any cycle if_req=0.
REQ-027 Single request present: grant it regardless of starve_cnt.
REQ-028 Fetch grant: IDLE->IF_WAIT. Next cycle: if_rvalid=1, if_rdata=mem_rdata, then ->IDLE.
REQ-029 Load grant: IDLE->LS_WAIT. Next cycle: ls_rvalid=1, ls_rdata=mem_rdata, then ->IDLE.
REQ-030 Store grant: single-cycle write, stay IDLE, no rvalid.
REQ-031 In WAIT states: ready=0 on both ports, mem_en=0.
REQ-032 Byte store: mem_we=0001<<addr[1:0]; mem_wdata={4{wdata[7:0]}}.
REQ-033 Half store: mem_we=0011<<{addr[1],0}; mem_wdata={2{wdata[15:0]}}.
REQ-034 Word store: mem_we=1111; mem_wdata=wdata.
REQ-035 Misaligned: half with addr[0]=1, or word/load with addr[1:0]!=00.
- Accepted (ls_ready=1) with ls_misaligned=1 in the same cycle.
- mem_en=0 and mem_we=0000; no rvalid; stay IDLE.
- Counts as an ls grant for starve_cnt.
REQ-036 Unused output data (rdata when rvalid=0) is don't-care; rvalid strobes are authoritative.
REQ-037 Throughput: one store per cycle; one read per 2 cycles.

Reset
REQ-038 On RST_N low, immediately: state=IDLE, starve_cnt=0, if_rvalid=0, ls_rvalid=0, if_rdata=0, ls_rdata=0.
REQ-039 During reset: all ready/en/we/misaligned outputs are 0.
REQ-040 A read in flight at reset is dropped; no rvalid after RST_N release.
REQ-041 The first grant is possible in the first cycle after RST_N rises.

Verification
REQ-042 Fetch only: if_req=1, if_addr=0x100, mem returns 0xDEADBEEF. Required: if_ready cycle N; if_rvalid=1 with if_rdata=0xDEADBEEF at N+1; next grant at N+2.
REQ-043 Byte store: ls_store_size=00, ls_addr=0x203, ls_wdata=0xAB. Required: mem_we=1000, mem_wdata=0xABABABAB, mem_addr=0x200, state stays IDLE.
REQ-044 Starvation, LS_MAX=4: if_req held with back-to-back ls stores. Required: exactly 4 ls grants, then an if grant, then ls resumes.
REQ-045 Misaligned: word load at 0x102. Required: ls_ready=1, ls_misaligned=1, mem_en=0, no ls_rvalid.
REQ-046 Reset mid-load: RST_N low in LS_WAIT cycle. Required: ls_rvalid=0 immediately and stays 0; state IDLE; first grant on the cycle after release.
REQ-047 Simultaneous if+ls, starve_cnt=0, load at 0x40. Required: ls granted first, ls_rvalid next cycle; if granted in the following IDLE cycle.
